// File: rtl/reg_writeback_ctrl.sv
// Write-side initiator for the register file: merges a queue of execute results and
// one outstanding load return onto a single registered write port. Optional macro: WB_BYPASS_EN.
module reg_writeback_ctrl #(
  parameter int REGBITS = 5,
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int RA      = 31
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [REGBITS-1:0]        ex_rdest,
  input  logic                      ex_link,
  input  logic [WIDTH-1:0]          ex_data,
  input  logic                      ld_issue,
  output logic                      ld_ready,
  input  logic [REGBITS-1:0]        ld_rdest,
  input  logic                      ld_valid,
  input  logic [WIDTH-1:0]          ld_data,
  output logic                      regWriteEn,
  output logic                      RaWriteEn,
  output logic [REGBITS-1:0]        Rdest,
  output logic [WIDTH-1:0]          writeData,
  output logic [(1<<REGBITS)-1:0]   busy_mask,
  output logic                      wb_err
);

  localparam int PTRW = $clog2(DEPTH);
  localparam logic [REGBITS-1:0] RA_IDX = REGBITS'(RA);

  logic                qLink [DEPTH];
  logic [REGBITS-1:0]  qDest [DEPTH];
  logic [WIDTH-1:0]    qData [DEPTH];
  logic [PTRW-1:0]     headPtr;
  logic [PTRW-1:0]     tailPtr;
  logic [PTRW:0]       count;
  logic                ldPending;
  logic [REGBITS-1:0]  ldDest;

  logic qFull;
  logic qEmpty;
  logic exAccept;
  logic exKeep;
  logic ldWrite;
  logic doPop;
  logic doPush;
  logic doBypass;

  assign qFull    = (count == (PTRW+1)'(DEPTH));
  assign qEmpty   = (count == '0);
  assign ex_ready = !qFull;
  assign ld_ready = !ldPending;
  assign exAccept = ex_valid && ex_ready;
  // Writes to r0 are accepted but dropped; link writes always target RA.
  assign exKeep   = exAccept && (ex_link || (ex_rdest != '0));
  assign ldWrite  = ld_valid && ldPending;
  assign doPop    = !ldWrite && !qEmpty;
`ifdef WB_BYPASS_EN
  assign doBypass = exKeep && qEmpty && !ldWrite;
`else
  assign doBypass = 1'b0;
`endif
  assign doPush   = exKeep && !doBypass;

  // NOTE: queue storage is deliberately not reset; an entry is only ever read when count covers it.
  always_ff @(posedge clk) begin
    if (doPush) begin
      qLink[tailPtr] <= ex_link;
      qDest[tailPtr] <= ex_link ? RA_IDX : ex_rdest;
      qData[tailPtr] <= ex_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      headPtr    <= '0;
      tailPtr    <= '0;
      count      <= '0;
      ldPending  <= 1'b0;
      ldDest     <= '0;
      wb_err     <= 1'b0;
      regWriteEn <= 1'b0;
      RaWriteEn  <= 1'b0;
      Rdest      <= '0;
      writeData  <= '0;
    end else begin
      if (doPush) tailPtr <= tailPtr + PTRW'(1);
      if (doPop)  headPtr <= headPtr + PTRW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + (PTRW+1)'(1);
        2'b01:   count <= count - (PTRW+1)'(1);
        default: count <= count;
      endcase

      // Load return wins the port; Rdest/writeData hold when nothing is presented.
      regWriteEn <= 1'b0;
      RaWriteEn  <= 1'b0;
      if (ldWrite) begin
        regWriteEn <= (ldDest != '0);
        Rdest      <= ldDest;
        writeData  <= ld_data;
      end else if (doPop) begin
        regWriteEn <= !qLink[headPtr];
        RaWriteEn  <= qLink[headPtr];
        Rdest      <= qDest[headPtr];
        writeData  <= qData[headPtr];
      end else if (doBypass) begin
        regWriteEn <= !ex_link;
        RaWriteEn  <= ex_link;
        Rdest      <= ex_link ? RA_IDX : ex_rdest;
        writeData  <= ex_data;
      end

      if (ldPending) begin
        if (ld_valid) ldPending <= 1'b0;
      end else if (ld_issue) begin
        ldPending <= 1'b1;
        ldDest    <= ld_rdest;
      end

      if ((ld_issue && ldPending) || (ld_valid && !ldPending)) wb_err <= 1'b1;
    end
  end

  logic [PTRW-1:0] slotOff;

  // NOTE: every variable of this always_comb gets a default before the loop, so no latch is inferred.
  always_comb begin
    busy_mask = '0;
    slotOff   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slotOff = PTRW'(i) - headPtr;
      if ({1'b0, slotOff} < count) busy_mask[qDest[i]] = 1'b1;
    end
    if (ldPending) busy_mask[ldDest] = 1'b1;
    busy_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Self-checking bench for reg_writeback_ctrl: vector table, corner sequences and a
// randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_reg_writeback_ctrl;

  localparam int REGBITS = 5;
  localparam int WIDTH   = 32;
  localparam int DEPTH   = 4;
  localparam int RA      = 31;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              ex_valid, ex_ready, ex_link;
  logic [4:0]        ex_rdest;
  logic [31:0]       ex_data;
  logic              ld_issue, ld_ready, ld_valid;
  logic [4:0]        ld_rdest;
  logic [31:0]       ld_data;
  logic              regWriteEn, RaWriteEn;
  logic [4:0]        Rdest;
  logic [31:0]       writeData;
  logic [31:0]       busy_mask;
  logic              wb_err;

  reg_writeback_ctrl #(.REGBITS(REGBITS), .WIDTH(WIDTH), .DEPTH(DEPTH), .RA(RA)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rdest(ex_rdest), .ex_link(ex_link), .ex_data(ex_data),
    .ld_issue(ld_issue), .ld_ready(ld_ready), .ld_rdest(ld_rdest), .ld_valid(ld_valid), .ld_data(ld_data),
    .regWriteEn(regWriteEn), .RaWriteEn(RaWriteEn), .Rdest(Rdest), .writeData(writeData),
    .busy_mask(busy_mask), .wb_err(wb_err)
  );

  typedef struct {
    bit rst; bit exValid; bit exLink; logic [4:0] exRdest; logic [31:0] exData;
    bit ldIssue; logic [4:0] ldRdest; bit ldValid; logic [31:0] ldData;
  } stim_t;

  typedef struct packed { logic link; logic [4:0] dest; logic [31:0] data; } entry_t;

  typedef struct {
    stim_t s; bit we; bit ra; logic [4:0] rd; logic [31:0] wd;
    logic [31:0] busy; bit exr; bit ldr; bit err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: pending writes as a plain FIFO plus one load slot.
  entry_t      mq[$];
  bit          mPend;
  logic [4:0]  mLdDest;
  bit          mErr;
  bit          mWe, mRa;
  logic [4:0]  mRd;
  logic [31:0] mWd;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic stim_t mk(bit rst, bit ev, bit el, logic [4:0] er, logic [31:0] ed,
                               bit li, logic [4:0] lr, bit lv, logic [31:0] ld);
    stim_t s;
    s.rst = rst; s.exValid = ev; s.exLink = el; s.exRdest = er; s.exData = ed;
    s.ldIssue = li; s.ldRdest = lr; s.ldValid = lv; s.ldData = ld;
    return s;
  endfunction

  function automatic vec_t v(stim_t s, bit we, bit ra, logic [4:0] rd, logic [31:0] wd,
                             logic [31:0] busy, bit exr, bit ldr, bit err);
    vec_t r;
    r.s = s; r.we = we; r.ra = ra; r.rd = rd; r.wd = wd;
    r.busy = busy; r.exr = exr; r.ldr = ldr; r.err = err;
    return r;
  endfunction

  function automatic logic [31:0] modelBusy();
    logic [31:0] m = '0;
    foreach (mq[i]) m[mq[i].dest] = 1'b1;
    if (mPend) m[mLdDest] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic modelAdvance(stim_t s);
    bit ldRet, keep, wasEmpty, byp;
    entry_t e;
    if (s.rst) begin
      mq.delete(); mPend = 0; mLdDest = '0; mErr = 0;
      mWe = 0; mRa = 0; mRd = '0; mWd = '0;
      return;
    end
    ldRet    = s.ldValid && mPend;
    keep     = s.exValid && (mq.size() < DEPTH) && (s.exLink || s.exRdest != 0);
    wasEmpty = (mq.size() == 0);
    byp      = 0;
`ifdef WB_BYPASS_EN
    byp = keep && wasEmpty && !ldRet;
`endif
    mWe = 0; mRa = 0;
    if (ldRet) begin
      mWe = (mLdDest != 0); mRd = mLdDest; mWd = s.ldData;
    end else if (!wasEmpty) begin
      e = mq.pop_front();
      mWe = !e.link; mRa = e.link; mRd = e.dest; mWd = e.data;
    end else if (byp) begin
      mWe = !s.exLink; mRa = s.exLink; mRd = s.exLink ? 5'(RA) : s.exRdest; mWd = s.exData;
    end
    if (keep && !byp) mq.push_back({s.exLink, s.exLink ? 5'(RA) : s.exRdest, s.exData});
    if ((s.ldIssue && mPend) || (s.ldValid && !mPend)) mErr = 1;
    if (mPend) begin
      if (s.ldValid) mPend = 0;
    end else if (s.ldIssue) begin
      mPend = 1; mLdDest = s.ldRdest;
    end
  endtask

  // Drive one cycle of stimulus, step the model, compare after the edge.
  task automatic apply(stim_t s, string tag);
    reset = s.rst; ex_valid = s.exValid; ex_link = s.exLink; ex_rdest = s.exRdest; ex_data = s.exData;
    ld_issue = s.ldIssue; ld_rdest = s.ldRdest; ld_valid = s.ldValid; ld_data = s.ldData;
    modelAdvance(s);
    @(posedge clk);
    #1;
    check($sformatf("%s.regWriteEn", tag), 64'(regWriteEn), 64'(mWe));
    check($sformatf("%s.RaWriteEn", tag), 64'(RaWriteEn), 64'(mRa));
    check($sformatf("%s.Rdest", tag), 64'(Rdest), 64'(mRd));
    check($sformatf("%s.writeData", tag), 64'(writeData), 64'(mWd));
    check($sformatf("%s.busy_mask", tag), 64'(busy_mask), 64'(modelBusy()));
    check($sformatf("%s.ex_ready", tag), 64'(ex_ready), 64'(mq.size() < DEPTH));
    check($sformatf("%s.ld_ready", tag), 64'(ld_ready), 64'(!mPend));
    check($sformatf("%s.wb_err", tag), 64'(wb_err), 64'(mErr));
    check($sformatf("%s.exclusive_en", tag), 64'(regWriteEn && RaWriteEn), 64'(0));
  endtask

  vec_t        tbl[16];
  logic [4:0]  seen[$];
  stim_t       s, idle;
  int          nextDest;
  bit          sawFull, accepted;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "init");

`ifndef WB_BYPASS_EN
    tbl[0]  = v(mk(1, 0, 0, 0, 0, 0, 0, 0, 0),                    0, 0, 0,  32'h0,        32'h0,        1, 1, 0);
    tbl[1]  = v(mk(0, 1, 0, 5, 32'hDEADBEEF, 0, 0, 0, 0),         0, 0, 0,  32'h0,        32'h20,       1, 1, 0);
    tbl[2]  = v(idle,                                             1, 0, 5,  32'hDEADBEEF, 32'h0,        1, 1, 0);
    tbl[3]  = v(idle,                                             0, 0, 5,  32'hDEADBEEF, 32'h0,        1, 1, 0);
    tbl[4]  = v(mk(0, 1, 1, 3, 32'h40, 0, 0, 0, 0),               0, 0, 5,  32'hDEADBEEF, 32'h80000000, 1, 1, 0);
    tbl[5]  = v(mk(0, 1, 0, 0, 32'h1111, 0, 0, 0, 0),             0, 1, 31, 32'h40,       32'h0,        1, 1, 0);
    tbl[6]  = v(idle,                                             0, 0, 31, 32'h40,       32'h0,        1, 1, 0);
    tbl[7]  = v(mk(0, 0, 0, 0, 0, 1, 7, 0, 0),                    0, 0, 31, 32'h40,       32'h80,       1, 0, 0);
    tbl[8]  = v(mk(0, 1, 0, 9, 32'h99, 0, 0, 0, 0),               0, 0, 31, 32'h40,       32'h280,      1, 0, 0);
    tbl[9]  = v(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678),         1, 0, 7,  32'h12345678, 32'h200,      1, 1, 0);
    tbl[10] = v(idle,                                             1, 0, 9,  32'h99,       32'h0,        1, 1, 0);
    tbl[11] = v(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD),              0, 0, 9,  32'h99,       32'h0,        1, 1, 1);
    tbl[12] = v(mk(0, 0, 0, 0, 0, 1, 2, 0, 0),                    0, 0, 9,  32'h99,       32'h4,        1, 0, 1);
    tbl[13] = v(mk(0, 0, 0, 0, 0, 1, 3, 0, 0),                    0, 0, 9,  32'h99,       32'h4,        1, 0, 1);
    tbl[14] = v(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h22),               1, 0, 2,  32'h22,       32'h0,        1, 1, 1);
    tbl[15] = v(mk(1, 1, 0, 4, 32'h4, 1, 4, 1, 32'h4),            0, 0, 0,  32'h0,        32'h0,        1, 1, 0);
    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].s, $sformatf("tbl%0d", i));
      check($sformatf("vec%0d.we", i), 64'(regWriteEn), 64'(tbl[i].we));
      check($sformatf("vec%0d.ra", i), 64'(RaWriteEn), 64'(tbl[i].ra));
      check($sformatf("vec%0d.rd", i), 64'(Rdest), 64'(tbl[i].rd));
      check($sformatf("vec%0d.wd", i), 64'(writeData), 64'(tbl[i].wd));
      check($sformatf("vec%0d.busy", i), 64'(busy_mask), 64'(tbl[i].busy));
      check($sformatf("vec%0d.exr", i), 64'(ex_ready), 64'(tbl[i].exr));
      check($sformatf("vec%0d.ldr", i), 64'(ld_ready), 64'(tbl[i].ldr));
      check($sformatf("vec%0d.err", i), 64'(wb_err), 64'(tbl[i].err));
    end
`endif

    // Fill: alternating r0 loads steal slots so the queue backs up; upstream holds each request.
    nextDest = 1; sawFull = 0;
    seen.delete();
    for (int i = 0; i < 30; i++) begin
      s = idle;
      s.ldIssue = (i % 2 == 0) && (i < 20);
      s.ldValid = (i % 2 == 1) && (i < 20);
      if (nextDest <= 8) begin
        s.exValid = 1; s.exRdest = 5'(nextDest); s.exData = 32'hC0000000 + 32'(nextDest);
      end
      accepted = s.exValid && ex_ready;
      if (!ex_ready) sawFull = 1;
      apply(s, $sformatf("fill%0d", i));
      if (accepted) nextDest++;
      if (regWriteEn) seen.push_back(Rdest);
    end
`ifndef WB_BYPASS_EN
    check("fill.saw_full", 64'(sawFull), 64'(1));
`endif
    check("fill.write_count", 64'(seen.size()), 64'(8));
    for (int j = 0; j < seen.size(); j++)
      check($sformatf("fill.order%0d", j), 64'(seen[j]), 64'(j + 1));

    // Load completion and a new issue in the same cycle.
    apply(mk(0, 0, 0, 0, 0, 1, 4, 0, 0), "ldpair0");
    apply(mk(0, 0, 0, 0, 0, 1, 6, 1, 32'h44), "ldpair1");
    check("ldpair.err", 64'(wb_err), 64'(1));
    check("ldpair.ld_ready", 64'(ld_ready), 64'(1));
    check("ldpair.rd", 64'(Rdest), 64'(4));

    // Reset with queued entries and a pending load.
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "rs0");
    apply(mk(0, 1, 0, 10, 32'hA, 1, 0, 0, 0), "rs1");
    apply(mk(0, 1, 0, 11, 32'hB, 0, 0, 1, 0), "rs2");
    apply(mk(0, 1, 0, 12, 32'hC, 1, 0, 0, 0), "rs3");
    apply(mk(0, 1, 0, 13, 32'hD, 0, 0, 1, 0), "rs4");
    apply(mk(0, 1, 0, 14, 32'hE, 1, 7, 0, 0), "rs5");
    apply(mk(1, 1, 0, 15, 32'hF, 0, 0, 1, 32'h77), "rs6");
    check("rst.we", 64'(regWriteEn), 64'(0));
    check("rst.ra", 64'(RaWriteEn), 64'(0));
    check("rst.busy", 64'(busy_mask), 64'(0));
    check("rst.ex_ready", 64'(ex_ready), 64'(1));
    check("rst.ld_ready", 64'(ld_ready), 64'(1));
    apply(idle, "rs7");
    check("rst.no_write", 64'(regWriteEn | RaWriteEn), 64'(0));

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      s = idle;
      s.rst     = ($urandom_range(0, 59) == 0);
      s.exValid = $urandom_range(0, 1);
      s.exLink  = ($urandom_range(0, 7) == 0);
      s.exRdest = 5'($urandom_range(0, 31));
      s.exData  = $urandom();
      s.ldIssue = ($urandom_range(0, 3) == 0);
      s.ldRdest = 5'($urandom_range(0, 31));
      s.ldValid = mPend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      s.ldData  = $urandom();
      apply(s, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
